bram_sdp_pipe: RTL and testbench
================================

Name: bram_sdp_pipe

Overview:
- Single-clock simple-dual-port block RAM with per-byte write enables and a read request/valid handshake.
- Read latency is configurable and read-during-write behaviour is selectable.
- A built-in clear sequencer zeroes the whole array on command.
- Successor to the generic two-clock BRAM. Used for CORDIC result buffers and UART frame storage where a valid strobe and bulk clear are needed.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of 8. NB = DATA_WIDTH/8.
- READ_LATENCY, 1, cycles from accepted read to o_rd_valid; legal values 1..3.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (write-first).

Ports:
- i_clk  in  1  single clock, all logic on posedge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_wr_en  in  1  write strobe.
- i_wr_be  in  NB  byte enables; bit k covers data[8k+7:8k].
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_WIDTH  read address.
- o_rd_data  out  DATA_WIDTH  read data; held between valids.
- o_rd_valid  out  1  one-cycle pulse, o_rd_data is valid.
- i_clr  in  1  start array clear (pulse).
- o_busy  out  1  clear sequence in progress.
- o_rd_perr  out  1  parity error on current valid read; 0 when the optional feature is compiled out.

Behaviour:
- Reset values: o_rd_data=0, o_rd_valid=0, o_busy=0, o_rd_perr=0. FSM=IDLE and the read pipeline is flushed. Memory contents are not reset.
- Write: on posedge with i_wr_en=1, o_busy=0 and i_wr_addr<DEPTH, byte k is written iff i_wr_be[k]=1.
  - i_wr_be=0 writes nothing.
  - Writes with address ≥ DEPTH are dropped.
- Read: accepted when i_rd_en=1 and o_busy=0.
  - o_rd_valid pulses exactly READ_LATENCY cycles after the accepting edge.
  - Back-to-back reads are accepted every cycle, giving a continuous valid stream in order.
  - Address ≥ DEPTH returns 0 with valid asserted.
  - o_rd_data updates only when a valid is produced; otherwise it holds.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns a merge; enabled bytes take the new data, disabled bytes keep the old word.
  - Different addresses do not interact.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on i_clr=1. A counter starts at 0, and o_busy=1 from the next cycle.
  - CLEAR writes all-zero to address cnt each cycle and increments cnt.
  - After writing DEPTH-1, the FSM returns to IDLE and o_busy drops the following cycle. Busy lasts exactly DEPTH cycles.
  - i_clr while busy is ignored.
  - i_clr together with i_wr_en in IDLE: clear wins and the write is dropped.
  - i_rd_en together with i_clr in IDLE: the read is accepted, since o_busy is still 0.
  - While busy, i_wr_en and i_rd_en are ignored (no valid generated).
  - Reads accepted before busy still complete through the pipeline.
- Reset mid-clear: immediate return to IDLE, o_busy=0. Memory is left partially cleared; no resume.
- Reset mid-read: in-flight valids are discarded.

Optional Feature:
- BRAM_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte and written with each enabled byte.
  - The clear sequence writes parity 0.
  - On each valid read, parity is recomputed. o_rd_perr=1 in the same cycle as o_rd_valid if any byte mismatches.
  - Bench hook: a hierarchical force on the parity array for error injection.
- Undefined: no parity storage, and o_rd_perr is tied to 0.

Test Plan:
- Write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 with READ_LATENCY=2 → o_rd_valid 2 cycles later, o_rd_data=0xDEADBEEF.
- Addr 5 holds 0xDEADBEEF; write 0x11223344 with be=4'b0101 → read returns 0xDE22BE44.
- RDW_MODE=0: addr 7 holds 0xAAAAAAAA; same-cycle write 0x55555555 and read of addr 7 → 0xAAAAAAAA, next read 0x55555555.
- RDW_MODE=1, same stimulus → first read 0x55555555.
- Pulse i_clr with DEPTH=16 → o_busy high exactly 16 cycles.
  - Writes and reads during busy are ignored, with no o_rd_valid.
  - Afterwards, reads of addr 0..15 all return 0.
- Assert i_rst_n=0 at clear cycle 4 → o_busy=0 immediately. Addr 0..3 read 0 and addr 10 retains its prior value.
- With BRAM_PARITY_EN, flip the stored parity bit of byte 1 at addr 3 → the read of addr 3 gives o_rd_perr=1 with o_rd_valid; a read of addr 4 gives o_rd_perr=0.

Source files
------------

// File: rtl/bram_sdp_pipe.sv
// Simple-dual-port RAM: byte-enable writes, request/valid reads, bulk clear sequencer.
// Latency: o_rd_valid/o_rd_data arrive READ_LATENCY cycles after the accepting edge; writes land on the edge.
// Backpressure: none on reads/writes; while o_busy is high (clear running) both ports are ignored.
// Optional: define BRAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on o_rd_perr.
module bram_sdp_pipe #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_clr,
  output logic                    o_busy,
  output logic                    o_rd_perr
);

  localparam int NB = DATA_WIDTH / 8;
  // Index width actually needed to address DEPTH words (at least one bit).
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       LAST_W  = IW'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          busy;

  logic          wr_fire;
  logic          rd_fire;
  logic          rd_in_range;
  logic [NB-1:0]         mem_be;
  logic [IW-1:0]         mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

`ifdef BRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;
  logic [NB-1:0] par_q [READ_LATENCY];
  logic [NB-1:0] par_d [READ_LATENCY];
`endif

  // Clear FSM state register and address counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next state: start on i_clr when idle, walk every word once, then go idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_W) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear FSM outputs: busy for the whole time the sequencer owns the write port.
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  assign o_busy = busy;

  // Port qualification: a clear request in the same cycle steals the write port.
  always_comb begin
    wr_fire     = i_wr_en && !busy && !i_clr && ({1'b0, i_wr_addr} < DEPTH_W);
    rd_fire     = i_rd_en && !busy;
    rd_in_range = ({1'b0, i_rd_addr} < DEPTH_W);
  end

  // Write-port mux: the clear sequencer writes a full zero word, otherwise the user write.
  always_comb begin
    mem_be = '0;
    mem_wa = '0;
    mem_wd = '0;
    if (busy) begin
      mem_be = '1;
      mem_wa = cnt_q;
    end else if (wr_fire) begin
      mem_be = i_wr_be;
      mem_wa = i_wr_addr[IW-1:0];
      mem_wd = i_wr_data;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_be[k]) begin
        mem[mem_wa][8*k +: 8] <= mem_wd[8*k +: 8];
`ifdef BRAM_PARITY_EN
        par_mem[mem_wa][k] <= ^mem_wd[8*k +: 8];
`endif
      end
    end
  end

  // Read word: out-of-range yields zero; write-first mode forwards enabled bytes of a colliding write.
  always_comb begin
    rd_word = '0;
`ifdef BRAM_PARITY_EN
    rd_par  = '0;
`endif
    if (rd_in_range) begin
      rd_word = mem[i_rd_addr[IW-1:0]];
`ifdef BRAM_PARITY_EN
      rd_par  = par_mem[i_rd_addr[IW-1:0]];
`endif
      if ((RDW_MODE == 1) && wr_fire && (i_wr_addr == i_rd_addr)) begin
        for (int k = 0; k < NB; k++) begin
          if (i_wr_be[k]) begin
            rd_word[8*k +: 8] = i_wr_data[8*k +: 8];
`ifdef BRAM_PARITY_EN
            rd_par[k] = ^i_wr_data[8*k +: 8];
`endif
          end
        end
      end
    end
  end

  // Read pipeline next state: data stages only load alongside a valid, so the output holds between valids.
  always_comb begin
    vld_d[0] = rd_fire;
    dat_d[0] = rd_fire ? rd_word : dat_q[0];
`ifdef BRAM_PARITY_EN
    par_d[0] = rd_fire ? rd_par : par_q[0];
`endif
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
`ifdef BRAM_PARITY_EN
      par_d[s] = vld_q[s-1] ? par_q[s-1] : par_q[s];
`endif
    end
  end

  // Read pipeline registers; reset flushes in-flight reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        dat_q[s] <= '0;
`ifdef BRAM_PARITY_EN
        par_q[s] <= '0;
`endif
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
`ifdef BRAM_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  assign o_rd_valid = vld_q[READ_LATENCY-1];
  assign o_rd_data  = dat_q[READ_LATENCY-1];

`ifdef BRAM_PARITY_EN
  // Parity check at the output stage, qualified by valid so it is a pulse like o_rd_valid.
  always_comb begin
    o_rd_perr = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if ((^dat_q[READ_LATENCY-1][8*k +: 8]) != par_q[READ_LATENCY-1][k]) begin
        o_rd_perr = o_rd_valid;
      end
    end
  end
`else
  assign o_rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Bench for bram_sdp_pipe: two instances share stimulus (latency 2 read-old, latency 3 write-first),
// each compared every cycle against a word-level memory model with an expected-read queue.
module tb_bram_sdp_pipe;

  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          busy_a, busy_b;
  logic          perr_a, perr_b;

  always #5 clk = ~clk;

  bram_sdp_pipe #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                  .READ_LATENCY(LAT_A), .RDW_MODE(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_be(wr_be),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .i_clr(clr), .o_busy(busy_a),
    .o_rd_perr(perr_a));

  bram_sdp_pipe #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                  .READ_LATENCY(LAT_B), .RDW_MODE(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_be(wr_be),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .i_clr(clr), .o_busy(busy_b),
    .o_rd_perr(perr_b));

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } exp_t;

  logic [DW-1:0] m_mem [DEPTH];
  exp_t          qa[$];
  exp_t          qb[$];
  int            cyc = 0;
  int            clr_left = 0;
  int            clr_addr = 0;
  logic          exp_vld_a = 1'b0, exp_vld_b = 1'b0, exp_busy = 1'b0;
  logic [DW-1:0] held_a = '0, held_b = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r = old_w;
    for (int k = 0; k < NB; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // The model applies the rules of one clock edge; exp_* describe the outputs after that edge.
  always @(posedge clk or negedge rst_n) begin
    int            wa, ra;
    logic          wr_ok;
    logic [DW-1:0] old_w, new_w;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      clr_left  = 0;
      exp_vld_a = 1'b0;
      exp_vld_b = 1'b0;
      exp_busy  = 1'b0;
      held_a    = '0;
      held_b    = '0;
    end else begin
      cyc++;
      wa = int'(wr_addr);
      ra = int'(rd_addr);
      if (clr_left > 0) begin
        m_mem[clr_addr] = '0;
        clr_addr++;
        clr_left--;
      end else begin
        wr_ok = wr_en && !clr && (wa < DEPTH);
        if (rd_en) begin
          old_w = (ra < DEPTH) ? m_mem[ra] : '0;
          new_w = old_w;
          if (wr_ok && (wa == ra) && (ra < DEPTH)) new_w = merge(old_w, wr_data, wr_be);
          qa.push_back('{due: cyc + LAT_A - 1, dat: old_w});
          qb.push_back('{due: cyc + LAT_B - 1, dat: new_w});
        end
        if (clr) begin
          clr_left = DEPTH;
          clr_addr = 0;
        end else if (wr_ok) begin
          m_mem[wa] = merge(m_mem[wa], wr_data, wr_be);
        end
      end
      exp_vld_a = 1'b0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        exp_vld_a = 1'b1;
        held_a    = qa[0].dat;
        void'(qa.pop_front());
      end
      exp_vld_b = 1'b0;
      if (qb.size() > 0 && qb[0].due == cyc) begin
        exp_vld_b = 1'b1;
        held_b    = qb[0].dat;
        void'(qb.pop_front());
      end
      exp_busy = (clr_left > 0);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("valid_a", rd_valid_a, exp_vld_a);
      check("data_a",  rd_data_a,  held_a);
      check("busy_a",  busy_a,     exp_busy);
      check("perr_a",  perr_a,     1'b0);
      check("valid_b", rd_valid_b, exp_vld_b);
      check("data_b",  rd_data_b,  held_b);
      check("busy_b",  busy_b,     exp_busy);
      check("perr_b",  perr_b,     1'b0);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr = 1'b0;
  endtask

  // Drive one cycle's worth of port activity, then return to idle.
  task automatic op(input logic we, input logic [NB-1:0] be, input int wa, input logic [DW-1:0] wd,
                    input logic re, input int ra, input logic c);
    wr_en = we; wr_be = be; wr_addr = AW'(wa); wr_data = wd;
    rd_en = re; rd_addr = AW'(ra); clr = c;
    step();
    idle_inputs();
  endtask

  task automatic rand_inputs();
    wr_en   = 1'($urandom_range(0, 1));
    wr_be   = NB'($urandom);
    wr_addr = AW'($urandom_range(0, 23));
    wr_data = $urandom;
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = AW'($urandom_range(0, 23));
    clr     = 1'b0;
  endtask

  // Wait (bounded) for the next valid of one instance and compare its data with a fixed value.
  task automatic expect_read(input string tag, input bit use_b, input logic [DW-1:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (use_b ? rd_valid_b : rd_valid_a) begin
        got = 1'b1;
        check(tag, use_b ? rd_data_b : rd_data_a, exp);
      end
    end
    if (!got) check({tag, "_timeout"}, got, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc_a, bc_b;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Initial clear gives the array defined contents.
    op(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    repeat (DEPTH + 1) step();

    // Full write then read; partial byte-enable update.
    op(1'b1, 4'hF, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    op(1'b0, '0, 0, '0, 1'b1, 5, 1'b0);
    expect_read("full_wr_a", 1'b0, 32'hDEADBEEF);
    expect_read("full_wr_b", 1'b1, 32'hDEADBEEF);
    op(1'b1, 4'b0101, 5, 32'h11223344, 1'b0, 0, 1'b0);
    op(1'b0, '0, 0, '0, 1'b1, 5, 1'b0);
    expect_read("byte_en_a", 1'b0, 32'hDE22BE44);
    expect_read("byte_en_b", 1'b1, 32'hDE22BE44);

    // Same-address read-during-write: instance a returns old data, b the merged word.
    op(1'b1, 4'hF, 7, 32'hAAAAAAAA, 1'b0, 0, 1'b0);
    op(1'b1, 4'hF, 7, 32'h55555555, 1'b1, 7, 1'b0);
    expect_read("rdw_a", 1'b0, 32'hAAAAAAAA);
    expect_read("rdw_b", 1'b1, 32'h55555555);
    op(1'b0, '0, 0, '0, 1'b1, 7, 1'b0);
    expect_read("rdw_next_a", 1'b0, 32'h55555555);
    expect_read("rdw_next_b", 1'b1, 32'h55555555);
    repeat (4) step();

    // Fill, then clear with a coincident write (dropped) and read (accepted); hammer ports while busy.
    for (int a = 0; a < DEPTH; a++) op(1'b1, 4'hF, a, $urandom, 1'b0, 0, 1'b0);
    op(1'b1, 4'hF, 2, 32'hCAFEF00D, 1'b1, 2, 1'b1);
    bc_a = int'(busy_a);
    bc_b = int'(busy_b);
    for (int i = 0; i < DEPTH + 2; i++) begin
      rand_inputs();
      step();
      bc_a += int'(busy_a);
      bc_b += int'(busy_b);
    end
    idle_inputs();
    check("busy_len_a", bc_a, DEPTH);
    check("busy_len_b", bc_b, DEPTH);
    for (int a = 0; a < 2 * DEPTH; a++) op(1'b0, '0, 0, '0, 1'b1, a, 1'b0);
    repeat (4) step();

    // Reset during clear cycle 4: busy drops at once, partial clear remains.
    for (int a = 0; a < DEPTH; a++) op(1'b1, 4'hF, a, $urandom | 32'h1, 1'b0, 0, 1'b0);
    op(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1;
    check("rst_clear_busy_a", busy_a, 1'b0);
    check("rst_clear_busy_b", busy_b, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < DEPTH; a++) op(1'b0, '0, 0, '0, 1'b1, a, 1'b0);
    repeat (4) step();

    // Reset with reads in flight discards them.
    op(1'b0, '0, 0, '0, 1'b1, 10, 1'b0);
    op(1'b0, '0, 0, '0, 1'b1, 11, 1'b0);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      clr = ($urandom_range(0, 149) == 0);
      step();
      idle_inputs();
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    idle_inputs();
    repeat (DEPTH + 8) step();

`ifdef BRAM_PARITY_EN
    begin
      int seen_a, seen_b;
      op(1'b1, 4'hF, 3, 32'h12345678, 1'b0, 0, 1'b0);
      op(1'b1, 4'hF, 4, 32'h0F0F0F0F, 1'b0, 0, 1'b0);
      step();
      chk_en = 1'b0;
      dut_a.par_mem[3][1] = ~dut_a.par_mem[3][1];
      dut_b.par_mem[3][1] = ~dut_b.par_mem[3][1];
      seen_a = 0;
      seen_b = 0;
      for (int i = 0; i < 8; i++) begin
        rd_en   = (i < 2);
        rd_addr = (i == 0) ? AW'(3) : AW'(4);
        @(negedge clk);
        if (rd_valid_a) begin
          check((seen_a == 0) ? "perr_addr3_a" : "perr_addr4_a", perr_a, (seen_a == 0));
          check((seen_a == 0) ? "pdat_addr3_a" : "pdat_addr4_a", rd_data_a,
                (seen_a == 0) ? 32'h12345678 : 32'h0F0F0F0F);
          seen_a++;
        end
        if (rd_valid_b) begin
          check((seen_b == 0) ? "perr_addr3_b" : "perr_addr4_b", perr_b, (seen_b == 0));
          seen_b++;
        end
      end
      idle_inputs();
      check("perr_valids_a", seen_a, 2);
      check("perr_valids_b", seen_b, 2);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
